// File: rtl/nn_data_buffer.sv
// Splits pushed words into a weight bank and an input FIFO. FIFO words are
// released to the compute core only while a complete weight set is loaded.
module nn_data_buffer #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned WEIGHT_ROWS = 8,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_push,
    input  logic                          is_weight,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          buf_clr,
    input  logic                          err_clr,
    input  logic                          in_ready,
    output logic                          in_valid,
    output logic [DATA_W-1:0]             in_data,
    output logic [DATA_W*WEIGHT_ROWS-1:0] weight_bus,
    output logic                          weights_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          err_overrun,
    output logic                          err_wbusy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ROW_W = $clog2(WEIGHT_ROWS);

    typedef enum logic [1:0] {
        W_EMPTY   = 2'd0,
        W_LOADING = 2'd1,
        W_READY   = 2'd2
    } wstate_e;

    wstate_e                                state_q, state_d;
    logic [ROW_W-1:0]                       row_cnt_q, row_cnt_d;
    logic [WEIGHT_ROWS-1:0][DATA_W-1:0]     rows_q, rows_d;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0]      mem_q, mem_d;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic [DATA_W-1:0]                      in_data_q, in_data_d;
    logic                                   in_valid_q, in_valid_d;
    logic                                   weights_valid_q, weights_valid_d;
    logic                                   fifo_full_q, fifo_full_d;
    logic                                   fifo_empty_q, fifo_empty_d;
    logic                                   err_overrun_q, err_overrun_d;
    logic                                   err_wbusy_q, err_wbusy_d;

    logic w_push;
    logic i_push;
    logic pop;
    logic do_write;
    logic overrun_set;
    logic wbusy_set;

    // Weight-bank FSM: load rows in order, reload only when no input is pending.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        rows_d    = rows_q;
        wbusy_set = 1'b0;
        w_push    = wr_en_push & is_weight;

        if (w_push) begin
            case (state_q)
                W_EMPTY: begin
                    rows_d[0] = push_data;
                    row_cnt_d = ROW_W'(1);
                    state_d   = W_LOADING;
                end
                W_LOADING: begin
                    rows_d[row_cnt_q] = push_data;
                    if (row_cnt_q == ROW_W'(WEIGHT_ROWS - 1)) begin
                        row_cnt_d = '0;
                        state_d   = W_READY;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
                W_READY: begin
                    if (fifo_empty_q && !in_valid_q) begin
                        rows_d[0] = push_data;
                        row_cnt_d = ROW_W'(1);
                        state_d   = W_LOADING;
                    end else begin
                        wbusy_set = 1'b1;
                    end
                end
                default: begin
                    state_d   = W_EMPTY;
                    row_cnt_d = '0;
                end
            endcase
        end

        if (buf_clr) begin
            state_d   = W_EMPTY;
            row_cnt_d = '0;
            rows_d    = '0;
            wbusy_set = 1'b0;
        end
    end

    // Input FIFO: a pop frees a slot in the same cycle, so push+pop works when full.
    always_comb begin
        i_push      = wr_en_push & ~is_weight;
        pop         = in_valid_q & in_ready;
        do_write    = i_push & (~fifo_full_q | pop);
        overrun_set = i_push & fifo_full_q & ~pop;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (do_write) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_write) - CNT_W'(pop);

        if (buf_clr) begin
            mem_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overrun_set = 1'b0;
        end

        in_data_d    = mem_d[rd_ptr_d];
        fifo_full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        fifo_empty_d = (count_d == '0);
    end

    // Status flags; a new error wins over a same-cycle err_clr.
    always_comb begin
        weights_valid_d = (state_d == W_READY);
        in_valid_d      = weights_valid_d & ~fifo_empty_d;
        err_overrun_d   = (err_overrun_q & ~err_clr) | overrun_set;
        err_wbusy_d     = (err_wbusy_q & ~err_clr) | wbusy_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= W_EMPTY;
            row_cnt_q       <= '0;
            rows_q          <= '0;
            mem_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            in_data_q       <= '0;
            in_valid_q      <= 1'b0;
            weights_valid_q <= 1'b0;
            fifo_full_q     <= 1'b0;
            fifo_empty_q    <= 1'b1;
            err_overrun_q   <= 1'b0;
            err_wbusy_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_cnt_q       <= row_cnt_d;
            rows_q          <= rows_d;
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            in_data_q       <= in_data_d;
            in_valid_q      <= in_valid_d;
            weights_valid_q <= weights_valid_d;
            fifo_full_q     <= fifo_full_d;
            fifo_empty_q    <= fifo_empty_d;
            err_overrun_q   <= err_overrun_d;
            err_wbusy_q     <= err_wbusy_d;
        end
    end

    assign in_valid      = in_valid_q;
    assign in_data       = in_data_q;
    assign weight_bus    = rows_q;
    assign weights_valid = weights_valid_q;
    assign fifo_count    = count_q;
    assign fifo_full     = fifo_full_q;
    assign fifo_empty    = fifo_empty_q;
    assign err_overrun   = err_overrun_q;
    assign err_wbusy     = err_wbusy_q;

endmodule

// File: tb/tb_nn_data_buffer.sv
// Bench for nn_data_buffer: directed scenarios then random traffic, all
// checked every cycle against a queue/array reference model.
module tb_nn_data_buffer;

    logic         clk;
    logic         rst;
    logic         wr_en_push;
    logic         is_weight;
    logic [63:0]  push_data;
    logic         buf_clr;
    logic         err_clr;
    logic         in_ready;
    logic         in_valid;
    logic [63:0]  in_data;
    logic [511:0] weight_bus;
    logic         weights_valid;
    logic [3:0]   fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         err_overrun;
    logic         err_wbusy;

    nn_data_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en_push    (wr_en_push),
        .is_weight     (is_weight),
        .push_data     (push_data),
        .buf_clr       (buf_clr),
        .err_clr       (err_clr),
        .in_ready      (in_ready),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .weight_bus    (weight_bus),
        .weights_valid (weights_valid),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .err_overrun   (err_overrun),
        .err_wbusy     (err_wbusy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending inputs as a queue, bank as an array of rows.
    logic [63:0] m_q[$];
    logic [63:0] m_w[8];
    int          m_loaded;
    bit          m_ready;
    bit          m_ovr;
    bit          m_wb;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_buf();
        m_q.delete();
        for (int i = 0; i < 8; i++) m_w[i] = '0;
        m_loaded = 0;
        m_ready  = 0;
    endtask

    task automatic model_edge();
        bit          do_pop;
        bit          novr;
        bit          nwb;
        logic [63:0] dummy;
        do_pop = m_ready && (m_q.size() != 0) && in_ready;
        novr   = 0;
        nwb    = 0;
        if (rst) begin
            model_clear_buf();
            m_ovr = 0;
            m_wb  = 0;
        end else begin
            if (buf_clr) begin
                model_clear_buf();
            end else begin
                if (wr_en_push && is_weight) begin
                    if (!m_ready) begin
                        m_w[m_loaded] = push_data;
                        m_loaded++;
                        if (m_loaded == 8) begin
                            m_ready  = 1;
                            m_loaded = 0;
                        end
                    end else if (m_q.size() == 0) begin
                        m_w[0]   = push_data;
                        m_loaded = 1;
                        m_ready  = 0;
                    end else begin
                        nwb = 1;
                    end
                end
                if (do_pop) dummy = m_q.pop_front();
                if (wr_en_push && !is_weight) begin
                    if (m_q.size() < 8) m_q.push_back(push_data);
                    else novr = 1;
                end
            end
            if (err_clr) begin
                m_ovr = 0;
                m_wb  = 0;
            end
            m_ovr = m_ovr | novr;
            m_wb  = m_wb | nwb;
        end
    endtask

    task automatic compare_all();
        logic [511:0] exp_bus;
        for (int i = 0; i < 8; i++) exp_bus[i*64 +: 64] = m_w[i];
        check("fifo_count", 512'(fifo_count), 512'(m_q.size()));
        check("fifo_empty", 512'(fifo_empty), 512'(m_q.size() == 0));
        check("fifo_full", 512'(fifo_full), 512'(m_q.size() == 8));
        check("weights_valid", 512'(weights_valid), 512'(m_ready));
        check("in_valid", 512'(in_valid), 512'(m_ready && m_q.size() != 0));
        check("weight_bus", weight_bus, exp_bus);
        check("err_overrun", 512'(err_overrun), 512'(m_ovr));
        check("err_wbusy", 512'(err_wbusy), 512'(m_wb));
        if (m_q.size() != 0) check("in_data", 512'(in_data), 512'(m_q[0]));
    endtask

    task automatic step(input logic r, input logic bc, input logic ec, input logic p,
                        input logic w, input logic [63:0] d, input logic rdy);
        rst        = r;
        buf_clr    = bc;
        err_clr    = ec;
        wr_en_push = p;
        is_weight  = w;
        push_data  = d;
        in_ready   = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic push_w(input logic [63:0] d, input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, d, rdy);
    endtask

    task automatic push_i(input logic [63:0] d, input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, rdy);
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b0;
        wr_en_push = 1'b0;
        is_weight  = 1'b0;
        push_data  = '0;
        buf_clr    = 1'b0;
        err_clr    = 1'b0;
        in_ready   = 1'b0;
        model_clear_buf();
        m_ovr = 0;
        m_wb  = 0;

        // Reset values and a first full weight load.
        do_reset();
        check("rst_in_data", 512'(in_data), 512'(0));
        check("rst_weight_bus", weight_bus, 512'(0));
        for (int i = 1; i <= 8; i++) push_w(64'(i), 1'b0);
        check("wload_valid", 512'(weights_valid), 512'(1));
        check("wload_row0", 512'(weight_bus[63:0]), 512'(64'h1));
        check("wload_row7", 512'(weight_bus[511:448]), 512'(64'h8));

        // Inputs held until weights are complete, then show-ahead pop.
        do_reset();
        push_i(64'hA0, 1'b0);
        push_i(64'hA1, 1'b0);
        check("hold_count", 512'(fifo_count), 512'(2));
        check("hold_valid", 512'(in_valid), 512'(0));
        for (int i = 0; i < 8; i++) push_w(64'h10 + 64'(i), 1'b0);
        check("rel_valid", 512'(in_valid), 512'(1));
        check("rel_data", 512'(in_data), 512'(64'hA0));
        idle(1'b1);
        check("pop_data", 512'(in_data), 512'(64'hA1));
        check("pop_count", 512'(fifo_count), 512'(1));
        idle(1'b1);

        // Overrun on the ninth push, then err_clr.
        for (int i = 0; i < 9; i++) begin
            push_i(64'hC0 + 64'(i), 1'b0);
            if (i == 7) check("full_after_8", 512'(fifo_full), 512'(1));
        end
        check("overrun_set", 512'(err_overrun), 512'(1));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        check("overrun_clr", 512'(err_overrun), 512'(0));
        check("count_kept", 512'(fifo_count), 512'(8));

        // Push and pop together while full; the new word drains last.
        push_i(64'hBB, 1'b1);
        check("fullpp_count", 512'(fifo_count), 512'(8));
        check("fullpp_ovr", 512'(err_overrun), 512'(0));
        for (int k = 0; k < 16 && fifo_count > 4'd1; k++) idle(1'b1);
        check("last_word", 512'(in_data), 512'(64'hBB));
        idle(1'b1);
        check("drained", 512'(fifo_empty), 512'(1));

        // Weight push rejected while input pending, accepted once drained.
        push_i(64'h77, 1'b0);
        push_w(64'h55, 1'b0);
        check("wbusy_set", 512'(err_wbusy), 512'(1));
        check("wbusy_row0", 512'(weight_bus[63:0]), 512'(64'h10));
        idle(1'b1);
        push_w(64'h55, 1'b0);
        check("reload_wv", 512'(weights_valid), 512'(0));
        check("reload_row0", 512'(weight_bus[63:0]), 512'(64'h55));

        // buf_clr mid-load together with an input push.
        push_w(64'h56, 1'b0);
        push_w(64'h57, 1'b0);
        push_w(64'h58, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h99, 1'b0);
        check("bclr_empty", 512'(fifo_empty), 512'(1));
        check("bclr_wv", 512'(weights_valid), 512'(0));
        check("bclr_errs", 512'({err_overrun, err_wbusy}), 512'(0));
        for (int i = 0; i < 8; i++) push_w(64'h200 + 64'(i), 1'b0);
        check("bclr_fresh_load", 512'(weights_valid), 512'(1));

        // Reset mid-stream.
        push_i(64'hD0, 1'b0);
        push_i(64'hD1, 1'b1);
        do_reset();
        check("rst2_in_data", 512'(in_data), 512'(0));
        check("rst2_valid", 512'(in_valid), 512'(0));

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 300) == 0, ($urandom % 80) == 0, ($urandom % 20) == 0,
                 ($urandom % 3) != 0, ($urandom % 3) == 0,
                 {$urandom, $urandom}, ($urandom % 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_data_buffer.md
Name: nn_data_buffer

Overview:
- Sits directly downstream of the AHB subordinate and consumes its push strobe (`wr_en_push`), the `is_weight` tag and the 64-bit write data.
- Weight words fill an 8-row weight bank; all other words enter an input FIFO.
- The input FIFO streams to the compute core over valid/ready, but only once the weight bank is complete.
- Returns full/empty/count status and sticky error bits to the subordinate for `status_reg` / `err_reg`.

Parameters:
- DATA_W, 64, width of one pushed word.
- WEIGHT_ROWS, 8, number of weight words forming one complete weight set.
- FIFO_DEPTH, 8, input FIFO entries (power of two).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- wr_en_push  in  1  one-cycle push strobe from the AHB subordinate.
- is_weight  in  1  tag for the pushed word: 1 = weight, 0 = input.
- push_data  in  DATA_W  pushed word.
- buf_clr  in  1  synchronous flush of the FIFO and weight bank.
- err_clr  in  1  clears the sticky error bits.
- in_ready  in  1  compute core accepts the input word.
- in_valid  out  1  input word available to the core.
- in_data  out  DATA_W  FIFO head word.
- weight_bus  out  DATA_W*WEIGHT_ROWS  weight bank; row 0 occupies the LSBs.
- weights_valid  out  1  weight bank complete.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  input FIFO occupancy.
- fifo_full  out  1  count == FIFO_DEPTH.
- fifo_empty  out  1  count == 0.
- err_overrun  out  1  sticky: input push dropped because the FIFO was full.
- err_wbusy  out  1  sticky: weight push rejected.

Behaviour:
- Reset (also `buf_clr`):
  - FIFO pointers and count go to 0; weight row counter goes to 0; weight-state FSM goes to W_EMPTY.
  - `in_valid` = 0, `weights_valid` = 0, `fifo_empty` = 1, `fifo_full` = 0.
  - `weight_bus` and `in_data` = 0 (registers are cleared).
- Error bits: reset clears them, `err_clr` clears them, `buf_clr` does not.
- Weight FSM, states W_EMPTY, W_LOADING, W_READY:
  - W_EMPTY + weight push: write row 0, row_cnt = 1, go to W_LOADING.
  - W_LOADING + weight push: write row[row_cnt], row_cnt++. The push that writes row WEIGHT_ROWS-1 moves the FSM to W_READY; `weights_valid` rises the next cycle.
  - W_READY + weight push:
    - If the FIFO is empty and `in_valid` is 0: reload. Write row 0, row_cnt = 1, go to W_LOADING; `weights_valid` falls the next cycle.
    - Otherwise: reject the word and set `err_wbusy`; the bank is unchanged.
  - Rows not yet rewritten keep their old values until overwritten.
- Input FIFO:
  - A push with `is_weight` = 0 writes at wr_ptr.
  - Push-to-visible latency is 1 cycle: the word pushed in cycle N is in the FIFO at N+1.
  - `in_valid` = `weights_valid` AND NOT `fifo_empty`.
  - Words may be pushed into the FIFO while weights are still loading; they are held until `weights_valid`.
  - Pop happens when `in_valid` AND `in_ready`. `in_data` is the head word (show-ahead) and advances the cycle after a pop.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is allowed even when the FIFO is full.
  - Push while full with no pop: word dropped, `err_overrun` set, no pointer change.
  - Pointers wrap modulo FIFO_DEPTH.
- Priority: rst > `buf_clr` > `err_clr`.
  - `buf_clr` wins over a same-cycle push or pop; the push is discarded with no error.
  - `err_clr` in the same cycle as a new error: the error bit ends up set.
- `wr_en_push` is held high for one cycle per word; held high for N cycles, it counts as N pushes.

Test Plan:
- Reset, then push 8 weights 0x1..0x8 on consecutive cycles → `weights_valid` = 1 one cycle after the 8th push; `weight_bus[63:0]` = 0x1 and `weight_bus[511:448]` = 0x8.
- Push inputs 0xA0, 0xA1 before any weights → `fifo_count` = 2 and `in_valid` = 0. Then load 8 weights → `in_valid` = 1 with `in_data` = 0xA0. Pop with `in_ready` = 1 → `in_data` = 0xA1, `fifo_count` = 1.
- With weights valid and `in_ready` = 0, push 9 inputs → `fifo_full` = 1 after the 8th push; the 9th is dropped and `err_overrun` = 1. Then pulse `err_clr` → `err_overrun` = 0, `fifo_count` still 8.
- FIFO full and `in_ready` = 1, push 0xBB in the same cycle → `fifo_count` stays 8 and `err_overrun` stays 0. After draining, 0xBB is the last word out; this also exercises pointer wrap.
- Weights valid, FIFO holding 1 word, push weight 0x55 → `err_wbusy` = 1 and the bank is unchanged. Drain the FIFO, push 0x55 → `weights_valid` = 0 next cycle and row 0 = 0x55.
- Halfway through a weight load (4 rows), assert `buf_clr` together with an input push → FIFO empty, FSM in W_EMPTY, no error bits set. Assert rst mid-stream → all outputs return to their reset values.
